// File: rtl/detonator_pkg.sv
// rtl/detonator_pkg.sv - shared encodings and helpers for the detonator control block
package detonator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTER = 3'd1,
        ST_ARMED = 3'd2,
        ST_FIRE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        P_NONE,
        P_SETUP,
        P_WAIT,
        P_FIRE,
        P_SURE,
        P_CONFIRM,
        P_READY
    } pulse_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_EARLY = 2'd1;
    localparam logic [1:0] ERR_COUNT = 2'd2;
    localparam logic [1:0] ERR_CODE  = 2'd3;

    localparam logic [3:0] BLANK_ALL = 4'hF;
    localparam logic [2:0] DIGITS    = 3'd4;

    // Only the highest-priority pulse in a cycle is allowed to act.
    function automatic pulse_e pick_pulse(input logic s, input logic w, input logic f,
                                          input logic su, input logic c, input logic r);
        if (s)       return P_SETUP;
        else if (w)  return P_WAIT;
        else if (f)  return P_FIRE;
        else if (su) return P_SURE;
        else if (c)  return P_CONFIRM;
        else if (r)  return P_READY;
        else         return P_NONE;
    endfunction

    // Entered digits are right-aligned, so unused positions blank from the left.
    function automatic logic [3:0] blank_mask(input logic [2:0] cnt);
        logic [3:0] m;
        m = BLANK_ALL << cnt;
        return m;
    endfunction

endpackage

// File: rtl/detonator_ctrl_if.sv
// rtl/detonator_ctrl_if.sv - key pulses in, lamp and display signals out
interface detonator_ctrl_if;
    import detonator_pkg::*;

    logic        wait_p;
    logic        setup_p;
    logic        ready_p;
    logic        fire_p;
    logic        sure_p;
    logic        confirm_p;
    logic [3:0]  A;
    logic [2:0]  state;
    logic        lt;
    logic        bt;
    logic        rt;
    logic [1:0]  err_code;
    logic [15:0] disp_data;
    logic [3:0]  disp_blank;

    modport master (
        output wait_p, setup_p, ready_p, fire_p, sure_p, confirm_p, A,
        input  state, lt, bt, rt, err_code, disp_data, disp_blank
    );

    modport slave (
        input  wait_p, setup_p, ready_p, fire_p, sure_p, confirm_p, A,
        output state, lt, bt, rt, err_code, disp_data, disp_blank
    );
endinterface

// File: rtl/detonator_ctrl_blink_timer.sv
// rtl/detonator_ctrl_blink_timer.sv - error lamp blinker, starts lit on enable
module blink_timer #(
    parameter int RT_CNT_MAX = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic out
);
    localparam int CW = (RT_CNT_MAX > 1) ? $clog2(RT_CNT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(RT_CNT_MAX - 1);

    logic          r_en_d;
    logic          r_out;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_d <= 1'b0;
            r_out  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_en_d <= en;
            if (!en) begin
                r_out <= 1'b0;
                r_cnt <= '0;
            end else if (!r_en_d) begin
                r_out <= 1'b1;
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_out <= ~r_out;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out = r_out;
endmodule

// File: rtl/detonator_ctrl.sv
// rtl/detonator_ctrl.sv - code-entry, arming and firing FSM with registered lamp/display outputs
module detonator_ctrl
    import detonator_pkg::*;
#(
    parameter logic [15:0] PASSWORD   = 16'h2580,
    parameter int          RT_CNT_MAX = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    detonator_ctrl_if.slave  bus
);
    state_e      r_state, w_next_state;
    logic [15:0] r_buf, w_next_buf;
    logic [2:0]  r_cnt, w_next_cnt;
    logic [1:0]  r_err, w_next_err;
    logic        r_lt, r_bt;
    logic [15:0] r_disp_data, w_next_data;
    logic [3:0]  r_disp_blank, w_next_blank;
    logic        w_rt;
    pulse_e      w_pulse;

    assign w_pulse = pick_pulse(bus.setup_p, bus.wait_p, bus.fire_p,
                                bus.sure_p, bus.confirm_p, bus.ready_p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_err        <= ERR_NONE;
            r_lt         <= 1'b0;
            r_bt         <= 1'b0;
            r_disp_data  <= '0;
            r_disp_blank <= BLANK_ALL;
        end else begin
            r_state      <= w_next_state;
            r_buf        <= w_next_buf;
            r_cnt        <= w_next_cnt;
            r_err        <= w_next_err;
            r_lt         <= (w_next_state == ST_ARMED);
            r_bt         <= (w_next_state == ST_FIRE);
            r_disp_data  <= w_next_data;
            r_disp_blank <= w_next_blank;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_buf   = r_buf;
        w_next_cnt   = r_cnt;
        w_next_err   = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pulse == P_READY) begin
                    w_next_state = ST_ENTER;
                    w_next_err   = ERR_NONE;
                end
            end
            ST_ENTER: begin
                unique case (w_pulse)
                    P_SETUP, P_WAIT: w_next_state = ST_IDLE;
                    P_FIRE: begin
                        w_next_state = ST_ERROR;
                        w_next_err   = ERR_EARLY;
                    end
                    P_SURE: begin
                        if (r_cnt != DIGITS) begin
                            w_next_state = ST_ERROR;
                            w_next_err   = ERR_COUNT;
                        end else if (r_buf == PASSWORD) begin
                            w_next_state = ST_ARMED;
                        end else begin
                            w_next_state = ST_ERROR;
                            w_next_err   = ERR_CODE;
                        end
                    end
                    P_CONFIRM: begin
                        if (r_cnt == DIGITS) begin
                            w_next_state = ST_ERROR;
                            w_next_err   = ERR_COUNT;
                        end else if (bus.A <= 4'd9) begin
                            w_next_buf = {r_buf[11:0], bus.A};
                            w_next_cnt = r_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_ARMED: begin
                if (w_pulse == P_FIRE)
                    w_next_state = ST_FIRE;
                else if (w_pulse == P_SETUP || w_pulse == P_WAIT)
                    w_next_state = ST_IDLE;
            end
            ST_FIRE: begin
                if (w_pulse == P_SETUP || w_pulse == P_WAIT)
                    w_next_state = ST_IDLE;
            end
            ST_ERROR: begin
                if (w_pulse == P_SETUP)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase

        // Any return to IDLE discards the entered code and error.
        if (w_next_state == ST_IDLE) begin
            w_next_buf = '0;
            w_next_cnt = '0;
            w_next_err = ERR_NONE;
        end

        w_next_data  = w_next_buf;
        w_next_blank = 4'h0;
        unique case (w_next_state)
            ST_IDLE:  w_next_blank = BLANK_ALL;
            ST_ENTER: w_next_blank = blank_mask(w_next_cnt);
            ST_ERROR: w_next_data  = {4'hE, 4'h0, 4'h0, 2'b00, w_next_err};
            default:  ;
        endcase
    end

    blink_timer #(.RT_CNT_MAX(RT_CNT_MAX)) u_blink (
        .clk (clk),
        .rst (rst),
        .en  (w_next_state == ST_ERROR),
        .out (w_rt)
    );

    assign bus.state      = r_state;
    assign bus.lt         = r_lt;
    assign bus.bt         = r_bt;
    assign bus.rt         = w_rt;
    assign bus.err_code   = r_err;
    assign bus.disp_data  = r_disp_data;
    assign bus.disp_blank = r_disp_blank;
endmodule

// File: tb/tb_detonator_ctrl.sv
// tb/tb_detonator_ctrl.sv - directed vector bench for detonator_ctrl
module tb_detonator_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    detonator_ctrl_if bus ();

    detonator_ctrl #(.PASSWORD(16'h2580), .RT_CNT_MAX(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse bit order: {setup, wait, fire, sure, confirm, ready}
    localparam logic [5:0] PN = 6'b000000;
    localparam logic [5:0] PS = 6'b100000;
    localparam logic [5:0] PW = 6'b010000;
    localparam logic [5:0] PF = 6'b001000;
    localparam logic [5:0] PU = 6'b000100;
    localparam logic [5:0] PC = 6'b000010;
    localparam logic [5:0] PR = 6'b000001;

    typedef struct {
        logic [5:0]  p;
        logic [3:0]  a;
        logic [2:0]  st;
        logic        lt;
        logic        bt;
        logic        rt;
        logic [1:0]  err;
        logic [15:0] data;
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs [31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] p, input logic [3:0] a);
        @(negedge clk);
        {bus.setup_p, bus.wait_p, bus.fire_p, bus.sure_p, bus.confirm_p, bus.ready_p} = p;
        bus.A = a;
        @(posedge clk);
        #1;
        {bus.setup_p, bus.wait_p, bus.fire_p, bus.sure_p, bus.confirm_p, bus.ready_p} = PN;
        bus.A = 4'h0;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".state"}, 32'(bus.state), 32'(v.st));
        chk({tag, ".lt"},    32'(bus.lt),    32'(v.lt));
        chk({tag, ".bt"},    32'(bus.bt),    32'(v.bt));
        chk({tag, ".rt"},    32'(bus.rt),    32'(v.rt));
        chk({tag, ".err"},   32'(bus.err_code), 32'(v.err));
        chk({tag, ".data"},  32'(bus.disp_data), 32'(v.data));
        chk({tag, ".blank"}, 32'(bus.disp_blank), 32'(v.blank));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        {bus.setup_p, bus.wait_p, bus.fire_p, bus.sure_p, bus.confirm_p, bus.ready_p} = PN;
        bus.A = 4'h0;

        //          pulse  A     st    lt    bt    rt    err   data      blank
        // correct sequence
        vecs[0]  = '{PR, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        vecs[1]  = '{PC, 4'h2, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0002, 4'hE};
        vecs[2]  = '{PC, 4'h5, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0025, 4'hC};
        vecs[3]  = '{PC, 4'h8, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0258, 4'h8};
        vecs[4]  = '{PC, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h2580, 4'h0};
        vecs[5]  = '{PU, 4'h0, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 16'h2580, 4'h0};
        vecs[6]  = '{PF, 4'h0, 3'd3, 1'b0, 1'b1, 1'b0, 2'd0, 16'h2580, 4'h0};
        vecs[7]  = '{PW, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        // long code, with a non-decimal digit ignored along the way
        vecs[8]  = '{PR, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        vecs[9]  = '{PC, 4'h3, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0003, 4'hE};
        vecs[10] = '{PC, 4'h2, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0032, 4'hC};
        vecs[11] = '{PC, 4'h8, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0328, 4'h8};
        vecs[12] = '{PC, 4'hA, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0328, 4'h8};
        vecs[13] = '{PC, 4'h1, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h3281, 4'h0};
        vecs[14] = '{PC, 4'h5, 3'd4, 1'b0, 1'b0, 1'b1, 2'd2, 16'hE002, 4'h0};
        vecs[15] = '{PW, 4'h0, 3'd4, 1'b0, 1'b0, 1'b0, 2'd2, 16'hE002, 4'h0};
        vecs[16] = '{PS, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        // wrong code
        vecs[17] = '{PR, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        vecs[18] = '{PC, 4'h3, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0003, 4'hE};
        vecs[19] = '{PC, 4'h2, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0032, 4'hC};
        vecs[20] = '{PC, 4'h8, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0328, 4'h8};
        vecs[21] = '{PC, 4'h1, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h3281, 4'h0};
        vecs[22] = '{PU, 4'h0, 3'd4, 1'b0, 1'b0, 1'b1, 2'd3, 16'hE003, 4'h0};
        vecs[23] = '{PS, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        // short code
        vecs[24] = '{PR, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        vecs[25] = '{PC, 4'h2, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0002, 4'hE};
        vecs[26] = '{PU, 4'h0, 3'd4, 1'b0, 1'b0, 1'b1, 2'd2, 16'hE002, 4'h0};
        vecs[27] = '{PS, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        // simultaneous pulses: setup outranks fire in ENTER and ready in IDLE
        vecs[28] = '{PR, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        vecs[29] = '{PF | PS, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};
        vecs[30] = '{PR | PS, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF};

        #12;
        chk_all("reset", '{PN, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'hF});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].p, vecs[i].a);
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // early fire: lamp blinks every cycle, wait cannot leave ERROR
        drive(PR, 4'h0);
        drive(PC, 4'h2);
        drive(PF, 4'h0);
        chk("early.state", 32'(bus.state), 32'd4);
        chk("early.err", 32'(bus.err_code), 32'd1);
        chk("early.rt0", 32'(bus.rt), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("early.rt%0d", k), 32'(bus.rt), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        drive(PW, 4'h0);
        chk("early.wait_state", 32'(bus.state), 32'd4);
        chk("early.wait_err", 32'(bus.err_code), 32'd1);
        drive(PS, 4'h0);
        chk("early.setup_state", 32'(bus.state), 32'd0);
        chk("early.setup_err", 32'(bus.err_code), 32'd0);
        chk("early.setup_rt", 32'(bus.rt), 32'd0);

        // asynchronous reset while armed
        drive(PR, 4'h0);
        drive(PC, 4'h2);
        drive(PC, 4'h5);
        drive(PC, 4'h8);
        drive(PC, 4'h0);
        drive(PU, 4'h0);
        chk("arm.state", 32'(bus.state), 32'd2);
        chk("arm.lt", 32'(bus.lt), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async.state", 32'(bus.state), 32'd0);
        chk("async.lt", 32'(bus.lt), 32'd0);
        chk("async.blank", 32'(bus.disp_blank), 32'hF);
        chk("async.data", 32'(bus.disp_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(PR, 4'h0);
        drive(PU, 4'h0);
        chk("post_reset.err", 32'(bus.err_code), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/detonator_ctrl.md
Name: detonator_ctrl

Overview:
- Central control FSM of the numeric-code detonator.
- Sits between the per-key debouncers (upstream, one-cycle pulses) and the lamp drivers and 7-segment scan driver (downstream).
- Collects 4 code digits from A, checks them against a preset code, and arms and fires on the correct sequence.
- Enters a latched error state on any misuse; only setup clears it.

Parameters:
- PASSWORD, 16'h2580, preset code as 4 BCD nibbles, first-entered digit in the MSB nibble.
- RT_CNT_MAX, 25_000_000, error-lamp half-period in clk cycles (minimum 1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wait_p  in  1  debounced wait_t pulse, 1 cycle wide
- setup_p  in  1  debounced setup pulse
- ready_p  in  1  debounced ready pulse
- fire_p  in  1  debounced fire pulse
- sure_p  in  1  debounced sure pulse
- confirm_p  in  1  debounced confirm pulse; A is sampled in the same cycle
- A  in  4  digit switches
- state  out  3  current FSM state code
- lt  out  1  armed lamp
- bt  out  1  detonation lamp
- rt  out  1  error lamp, blinking
- err_code  out  2  0 none, 1 early fire, 2 digit-count error, 3 wrong code
- disp_data  out  16  four BCD nibbles to scan driver; nibble 3 is leftmost
- disp_blank  out  4  per-digit blank mask to scan driver

Behaviour:
- Reset values: all outputs 0 except disp_blank=4'hF; state=IDLE; digit buffer buf=0; digit count cnt=0.
- All outputs are registered. They reflect a pulse one clk after the pulse cycle.
- States: IDLE=0, ENTER=1, ARMED=2, FIRE=3, ERROR=4.
- Priority when several pulses share a cycle: setup > wait > fire > sure > confirm > ready. Only the highest-priority pulse acts.
- IDLE:
  - ready -> ENTER, clearing buf, cnt and err_code.
  - All other pulses are ignored.
- ENTER:
  - setup or wait -> IDLE (abort).
  - fire -> ERROR with err_code=1.
  - sure with cnt==4 and buf==PASSWORD -> ARMED.
  - sure with cnt!=4 -> ERROR with err_code=2.
  - sure with cnt==4 and buf!=PASSWORD -> ERROR with err_code=3.
  - confirm with cnt<4 and A<=9: buf <= {buf[11:0],A}, cnt+1.
  - confirm with cnt==4 -> ERROR with err_code=2 (5th digit).
  - confirm with A>9 is ignored.
  - ready is ignored.
- ARMED:
  - fire -> FIRE.
  - setup or wait -> IDLE.
  - Other pulses are ignored.
- FIRE: setup or wait -> IDLE; all others are ignored.
- ERROR: only setup -> IDLE, which clears err_code; wait and all other pulses are ignored.
- Lamps:
  - lt=1 only in ARMED.
  - bt=1 only in FIRE.
  - rt=0 outside ERROR. On entry to ERROR, rt=1 and the blink counter clears. rt toggles every RT_CNT_MAX cycles.
- Display:
  - IDLE: disp_blank=4'hF.
  - ENTER: disp_data=buf; disp_blank[i]=1 for i>=cnt, i.e. entered digits are right-aligned.
  - ARMED and FIRE: disp_data=buf, disp_blank=0.
  - ERROR: disp_data={4'hE,4'h0,4'h0,2'b0,err_code}, disp_blank=0.
- Entering IDLE from any state clears buf and cnt.
- rst asserted mid-operation returns to reset values immediately; there is no retained code.

Decomposition:
- Package detonator_pkg: state encodings, err_code constants, BCD blank nibble, digit count constant 4.
- One sub-module, blink_timer: parameter RT_CNT_MAX; ports clk, rst, en, out. out forces 1 when en rises and toggles every RT_CNT_MAX cycles while en is high. It drives rt.

Test Plan:
- Correct sequence, RT_CNT_MAX=1:
  - Stimulus: ready; confirm with A=2,5,8,0; sure; fire; wait.
  - Required: state 0->1->2->3->0; disp_data=16'h2580 with disp_blank=0 in ARMED; lt=1 then bt=1; final disp_blank=4'hF.
- Early fire:
  - Stimulus: ready; confirm A=2; fire; wait; setup.
  - Required: ERROR with err_code=1; rt toggles each cycle; wait leaves state=4; setup -> IDLE with err_code=0 and rt=0.
- Short code:
  - Stimulus: ready; one confirm A=2; sure.
  - Required: err_code=2, disp_data=16'hE002.
  - Stimulus: setup. Required: IDLE.
- Long code:
  - Stimulus: ready; confirm A=3,2,8,1, then a 5th confirm.
  - Required: err_code=2 on the 5th confirm; disp_blank sequence F->E->C->8->0 before it.
- Wrong code:
  - Stimulus: ready; confirm A=3,2,8,1; sure.
  - Required: err_code=3, state=4.
- Simultaneous pulses and reset:
  - Stimulus: in ENTER, fire and setup in the same cycle. Required: IDLE, no error.
  - Stimulus: in ARMED, async rst mid-cycle. Required: state=0, lt=0 immediately.
  - Stimulus: confirm with A=4'hA. Required: cnt unchanged.
